// File: rtl/vga_scope_multi_if.sv
// Video-side bundle of the multi-channel scope renderer.
//   master : the sample source / display consumer (drives ena, dat, freeze,
//            grid_en; receives sync, strobes and colour)
//   slave  : the renderer itself
// Signals:
//   ena      pixel enable
//   dat      packed samples, channel k = dat[k*SW +: SW]
//   freeze   suppress sample capture
//   grid_en  draw grid lines inside the windows
//   hsync    active-low horizontal sync (registered)
//   vsync    active-low vertical sync (registered)
//   hline    capture strobe (combinational)
//   frame    one-clock pulse at x=0,y=0 (registered)
//   r,g,b    2-bit colour components (registered)
interface vga_scope_multi_if #(
  parameter int unsigned NCH = 2,
  parameter int unsigned SW  = 4
);
  logic               ena;
  logic [NCH*SW-1:0]  dat;
  logic               freeze;
  logic               grid_en;
  logic               hsync;
  logic               vsync;
  logic               hline;
  logic               frame;
  logic [1:0]         r;
  logic [1:0]         g;
  logic [1:0]         b;

  modport master (
    output ena, dat, freeze, grid_en,
    input  hsync, vsync, hline, frame, r, g, b
  );

  modport slave (
    input  ena, dat, freeze, grid_en,
    output hsync, vsync, hline, frame, r, g, b
  );
endinterface

// File: rtl/vga_scope_multi.sv
// Multi-channel VGA oscilloscope renderer, 640x480@60 (800x525 total).
// Once per odd scanline each channel's SW-bit sample is captured; every
// channel is drawn in its own CH_W-pixel window as a horizontal bar spanning
// min..max of its previous and current sample, over a checker background,
// with an optional grid. All video outputs are registered (1 enabled clock
// of latency relative to x,y).
// Ports:
//   clock  pixel clock
//   reset  synchronous, active-high; has priority over bus.ena
//   bus    vga_scope_multi_if slave modport (ena, dat, freeze, grid_en in;
//          hsync, vsync, hline, frame, r, g, b out)
module vga_scope_multi #(
  parameter int unsigned NCH   = 2,
  parameter int unsigned SW    = 4,
  parameter int unsigned CH_W  = 128,
  parameter int unsigned GAP   = 64,
  parameter int unsigned X0    = 96,
  parameter logic [5:0]  TRACE = 6'h3f,
  parameter logic [5:0]  GRIDC = 6'h15
) (
  input logic clock,
  input logic reset,
  vga_scope_multi_if.slave bus
);

  localparam int unsigned LW    = $clog2(CH_W);
  localparam int unsigned U     = CH_W >> SW;
  localparam int unsigned PITCH = CH_W + GAP;

  if (NCH < 1 || NCH > 4) begin : g_bad_nch
    $error("NCH must be 1..4");
  end
  if (SW < 1 || SW > 4) begin : g_bad_sw
    $error("SW must be 1..4");
  end
  if (CH_W < 16 || CH_W > 256 || (CH_W & (CH_W - 1)) != 0) begin : g_bad_chw
    $error("CH_W must be a power of two in 16..256");
  end
  if (X0 + NCH * CH_W + (NCH - 1) * GAP > 640) begin : g_bad_fit
    $error("channel windows do not fit in 640 pixels");
  end

  // Raster counters
  logic [9:0] x, y;
  logic [9:0] nx, ny;

  always_comb begin
    nx = x + 10'd1;
    ny = y;
    if (x == 10'd799) begin
      nx = '0;
      ny = (y == 10'd524) ? '0 : y + 10'd1;
    end
  end

  assign bus.hline = bus.ena & (x == 10'd640) & y[0];

  // Window tracker: state/index/local counter describe the current x.
  // Transitions are computed from nx so they land together with x.
  typedef enum logic {W_GAP, W_IN} wstate_t;

  wstate_t        ws_q, ws_d;
  logic [2:0]     widx_q, widx_d;
  logic [10:0]    wst_q, wst_d;
  logic [LW-1:0]  lx_q, lx_d;

  always_comb begin
    ws_d   = ws_q;
    widx_d = widx_q;
    wst_d  = wst_q;
    lx_d   = lx_q + LW'(1);
    if (nx == '0) begin
      ws_d   = (X0 == 0) ? W_IN : W_GAP;
      widx_d = '0;
      wst_d  = 11'(X0);
      lx_d   = '0;
    end else begin
      case (ws_q)
        W_IN: begin
          if (lx_q == LW'(CH_W - 1)) begin
            widx_d = widx_q + 3'd1;
            wst_d  = wst_q + 11'(PITCH);
            lx_d   = '0;
            // Abutting windows (GAP==0) re-enter immediately.
            ws_d   = (GAP == 0 && (widx_q + 3'd1) < 3'(NCH)) ? W_IN : W_GAP;
          end
        end
        W_GAP: begin
          if (widx_q < 3'(NCH) && {1'b0, nx} == wst_q) begin
            ws_d = W_IN;
            lx_d = '0;
          end
        end
        default: ws_d = W_GAP;
      endcase
    end
  end

  // Sample storage
  logic [SW-1:0] cur  [NCH];
  logic [SW-1:0] prev [NCH];
  logic [SW-1:0] lo   [NCH];
  logic [SW-1:0] hi   [NCH];

  // Pixel decode for the current x,y
  logic [SW-1:0]  lo_s, hi_s;
  logic [LW+1:0]  lx_e, lo_px, hi_lim;
  logic           trace_hit, visible;
  logic [5:0]     bg, pix_d;
  logic           hs_d, vs_d, fr_d;

  always_comb begin
    lo_s = '0;
    hi_s = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (widx_q == 3'(k)) begin
        lo_s = lo[k];
        hi_s = hi[k];
      end
    end
    lx_e   = (LW+2)'(lx_q);
    lo_px  = (LW+2)'(lo_s) * (LW+2)'(U);
    // Upper end compared as lx+1 <= hi*U + U/2 so U==1 needs no negative term.
    hi_lim = (LW+2)'(hi_s) * (LW+2)'(U) + (LW+2)'(U / 2);
    trace_hit = (lx_e >= lo_px) && ((lx_e + (LW+2)'(1)) <= hi_lim);

    visible = (x < 10'd640) && (y < 10'd480);
    bg      = (x[6:1] ^ y[6:1]) & 6'b011000;

    pix_d = '0;
    if (visible) begin
      if (ws_q == W_IN) begin
        if (trace_hit)
          pix_d = TRACE;
        else if (bus.grid_en && lx_q[3:0] == 4'd0)
          pix_d = GRIDC;
        else
          pix_d = bg;
      end else begin
        pix_d = bg;
      end
    end

    hs_d = !((x >= 10'd656) && (x <= 10'd751));
    vs_d = !((y >= 10'd490) && (y <= 10'd491));
    fr_d = (x == '0) && (y == '0);
  end

  logic       hs_q, vs_q, fr_q;
  logic [5:0] pix_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      x      <= '0;
      y      <= '0;
      ws_q   <= (X0 == 0) ? W_IN : W_GAP;
      widx_q <= '0;
      wst_q  <= 11'(X0);
      lx_q   <= '0;
      for (int unsigned k = 0; k < NCH; k++) begin
        cur[k]  <= '0;
        prev[k] <= '0;
        lo[k]   <= '0;
        hi[k]   <= '0;
      end
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      fr_q  <= 1'b0;
      pix_q <= '0;
    end else if (bus.ena) begin
      x      <= nx;
      y      <= ny;
      ws_q   <= ws_d;
      widx_q <= widx_d;
      wst_q  <= wst_d;
      lx_q   <= lx_d;
      for (int unsigned k = 0; k < NCH; k++) begin
        if (x == 10'd640 && y[0] && !bus.freeze) begin
          prev[k] <= cur[k];
          cur[k]  <= bus.dat[k*SW +: SW];
        end
        // min/max trail the capture by one enabled cycle
        lo[k] <= (prev[k] < cur[k]) ? prev[k] : cur[k];
        hi[k] <= (prev[k] < cur[k]) ? cur[k]  : prev[k];
      end
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      fr_q  <= fr_d;
      pix_q <= pix_d;
    end
  end

  assign bus.hsync = hs_q;
  assign bus.vsync = vs_q;
  assign bus.frame = fr_q;
  assign bus.r     = pix_q[5:4];
  assign bus.g     = pix_q[3:2];
  assign bus.b     = pix_q[1:0];

endmodule

// File: tb/tb_vga_scope_multi.sv
// Scoreboard bench for vga_scope_multi (NCH=2, SW=4, CH_W=128, GAP=64, X0=96).
// Expected values are queued against the clock-cycle index at which the DUT
// must present them; a negedge monitor pops and compares.
module tb_vga_scope_multi;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  vga_scope_multi_if #(.NCH(2), .SW(4)) bus();

  vga_scope_multi #(
    .NCH(2), .SW(4), .CH_W(128), .GAP(64), .X0(96),
    .TRACE(6'h3f), .GRIDC(6'h15)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  localparam int K_RGB = 0, K_HS = 1, K_VS = 2, K_FR = 3, K_HL = 4;

  typedef struct {
    int unsigned cyc;
    int          kind;
    logic [5:0]  val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   nchk  = 0;
  int   nfail = 0;

  function automatic void expect_at(int unsigned c, int kind, logic [5:0] v, string nm);
    exp_t e;
    int i;
    e.cyc = c; e.kind = kind; e.val = v; e.name = nm;
    i = 0;
    while (i < sb.size() && sb[i].cyc <= c) i++;
    sb.insert(i, e);
  endfunction

  function automatic logic [5:0] bgc(int x, int y);
    logic [9:0] xv, yv;
    xv = 10'(x);
    yv = 10'(y);
    return (xv[6:1] ^ yv[6:1]) & 6'b011000;
  endfunction

  // Constant enable: pixel (x,y) appears after edge b+1+y*800+x; x,y state at b+y*800+x.
  function automatic int unsigned pix(int unsigned b, int x, int y);
    return b + 1 + 32'(y * 800 + x);
  endfunction
  function automatic int unsigned pos(int unsigned b, int x, int y);
    return b + 32'(y * 800 + x);
  endfunction

  exp_t       mon_e;
  logic [5:0] act;

  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      case (mon_e.kind)
        K_RGB:   act = {bus.r, bus.g, bus.b};
        K_HS:    act = {5'b0, bus.hsync};
        K_VS:    act = {5'b0, bus.vsync};
        K_FR:    act = {5'b0, bus.frame};
        default: act = {5'b0, bus.hline};
      endcase
      nchk++;
      if (mon_e.cyc != cyc) begin
        nfail++;
        $display("FAIL %s: check slot %0d passed unseen (now %0d)", mon_e.name, mon_e.cyc, cyc);
      end else if (act !== mon_e.val) begin
        nfail++;
        $display("FAIL %s @%0d: got %h, expected %h", mon_e.name, cyc, act, mon_e.val);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_cyc(int unsigned t);
    while (cyc < t) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int unsigned b, b2;

  initial begin
    reset       = 1'b1;
    bus.ena     = 1'b1;
    bus.dat     = 8'h03;
    bus.freeze  = 1'b0;
    bus.grid_en = 1'b0;
    repeat (3) step();
    b = cyc;
    reset = 1'b0;

    // Reset state and frame pulse
    expect_at(b, K_RGB, 6'h00, "rst_rgb");
    expect_at(b, K_HS,  6'h01, "rst_hsync");
    expect_at(b, K_VS,  6'h01, "rst_vsync");
    expect_at(b, K_FR,  6'h00, "rst_frame");
    expect_at(b, K_HL,  6'h00, "rst_hline");
    expect_at(b + 1, K_FR, 6'h01, "frame_pulse");
    expect_at(b + 2, K_FR, 6'h00, "frame_end");

    // Line 0: lo=hi=0 -> bar lx 0..3
    expect_at(pix(b, 95, 0),  K_RGB, bgc(95, 0),  "l0_x95_bg");
    expect_at(pix(b, 96, 0),  K_RGB, 6'h3f,       "l0_lx0_trace");
    expect_at(pix(b, 99, 0),  K_RGB, 6'h3f,       "l0_lx3_trace");
    expect_at(pix(b, 100, 0), K_RGB, bgc(100, 0), "l0_lx4_bg");

    // hline strobe
    expect_at(pos(b, 639, 1), K_HL, 6'h00, "hline_x639");
    expect_at(pos(b, 640, 1), K_HL, 6'h01, "hline_odd");
    expect_at(pos(b, 640, 2), K_HL, 6'h00, "hline_even");
    expect_at(pos(b, 640, 5), K_HL, 6'h01, "hline_frozen");

    // Line 2: prev 0, cur 3 -> lx 0..27
    expect_at(pix(b, 123, 2), K_RGB, 6'h3f,       "l2_lx27_trace");
    expect_at(pix(b, 124, 2), K_RGB, bgc(124, 2), "l2_lx28_bg");

    // Line 4: ch0 3/9 -> lx 24..75; ch1 0 -> lx 0..3
    expect_at(pix(b, 95, 4),  K_RGB, 6'h08, "l4_x95_bg");
    expect_at(pix(b, 119, 4), K_RGB, 6'h18, "l4_lx23_bg");
    expect_at(pix(b, 120, 4), K_RGB, 6'h3f, "l4_lx24_trace");
    expect_at(pix(b, 171, 4), K_RGB, 6'h3f, "l4_lx75_trace");
    expect_at(pix(b, 172, 4), K_RGB, 6'h10, "l4_lx76_bg");
    expect_at(pix(b, 224, 4), K_RGB, 6'h10, "l4_after_win0");
    expect_at(pix(b, 288, 4), K_RGB, 6'h3f, "l4_ch1_lx0");
    expect_at(pix(b, 291, 4), K_RGB, 6'h3f, "l4_ch1_lx3");
    expect_at(pix(b, 292, 4), K_RGB, 6'h10, "l4_ch1_lx4_bg");
    expect_at(pix(b, 640, 4), K_RGB, 6'h00, "l4_blank");
    expect_at(pix(b, 655, 4), K_HS,  6'h01, "hs_655");
    expect_at(pix(b, 656, 4), K_HS,  6'h00, "hs_656");
    expect_at(pix(b, 751, 4), K_HS,  6'h00, "hs_751");
    expect_at(pix(b, 752, 4), K_HS,  6'h01, "hs_752");

    // Line 8: frozen across lines 5 and 7, bar still lx 24..75
    expect_at(pix(b, 119, 8), K_RGB, bgc(119, 8), "l8_frz_lx23");
    expect_at(pix(b, 120, 8), K_RGB, 6'h3f,       "l8_frz_lx24");
    expect_at(pix(b, 171, 8), K_RGB, 6'h3f,       "l8_frz_lx75");
    expect_at(pix(b, 172, 8), K_RGB, bgc(172, 8), "l8_frz_lx76");

    // Line 10: prev 9, cur 15 -> lx 72..123
    expect_at(pix(b, 167, 10), K_RGB, bgc(167, 10), "l10_lx71_bg");
    expect_at(pix(b, 168, 10), K_RGB, 6'h3f,        "l10_lx72_trace");
    expect_at(pix(b, 219, 10), K_RGB, 6'h3f,        "l10_lx123_trace");
    expect_at(pix(b, 220, 10), K_RGB, bgc(220, 10), "l10_lx124_bg");

    // Line 12: lo=hi=15 -> lx 120..123, grid on
    expect_at(pix(b, 0, 12),   K_VS,  6'h01,        "vs_line12");
    expect_at(pix(b, 95, 12),  K_RGB, bgc(95, 12),  "l12_x95_nogrid");
    expect_at(pix(b, 96, 12),  K_RGB, 6'h15,        "l12_grid_lx0");
    expect_at(pix(b, 97, 12),  K_RGB, bgc(97, 12),  "l12_lx1_bg");
    expect_at(pix(b, 112, 12), K_RGB, 6'h15,        "l12_grid_lx16");
    expect_at(pix(b, 208, 12), K_RGB, 6'h15,        "l12_grid_lx112");
    expect_at(pix(b, 216, 12), K_RGB, 6'h3f,        "l12_lx120_trace");
    expect_at(pix(b, 219, 12), K_RGB, 6'h3f,        "l12_lx123_trace");
    expect_at(pix(b, 220, 12), K_RGB, bgc(220, 12), "l12_lx124_bg");
    expect_at(pix(b, 288, 12), K_RGB, 6'h3f,        "l12_ch1_trace_over_grid");
    expect_at(pix(b, 304, 12), K_RGB, 6'h15,        "l12_ch1_grid_lx16");
    expect_at(pix(b, 415, 12), K_RGB, bgc(415, 12), "l12_ch1_lx127");
    expect_at(pix(b, 416, 12), K_RGB, bgc(416, 12), "l12_after_win1");

    wait_cyc(b + 1600);  bus.dat = 8'h09;
    wait_cyc(b + 3200);  bus.freeze = 1'b1; bus.dat = 8'h01;
    wait_cyc(b + 4800);  bus.dat = 8'h05;
    wait_cyc(b + 6400);  bus.freeze = 1'b0; bus.dat = 8'h0f;
    wait_cyc(b + 8000);  bus.grid_en = 1'b1;

    // Mid-line reset at x=300,y=13, then alternating enable
    wait_cyc(pos(b, 300, 13));
    reset = 1'b1;
    step();
    reset = 1'b0;
    b2 = cyc;
    bus.ena = 1'b1;

    expect_at(b2,     K_RGB, 6'h00, "rst2_rgb");
    expect_at(b2,     K_HS,  6'h01, "rst2_hsync");
    expect_at(b2,     K_VS,  6'h01, "rst2_vsync");
    expect_at(b2,     K_FR,  6'h00, "rst2_frame");
    expect_at(b2 + 1, K_FR,  6'h01, "rst2_frame_pulse");
    expect_at(b2 + 2, K_FR,  6'h01, "ena0_frame_hold");
    expect_at(b2 + 3, K_FR,  6'h00, "ena_frame_end");
    // Pixel p shows after edge b2+2p+1 and holds through b2+2p+2
    expect_at(b2 + 2*96 + 1,  K_RGB, 6'h3f,       "tog_l0_lx0");
    expect_at(b2 + 2*96 + 2,  K_RGB, 6'h3f,       "tog_l0_lx0_hold");
    expect_at(b2 + 2*100 + 1, K_RGB, bgc(100, 0), "tog_l0_lx4");
    expect_at(b2 + 2*100 + 2, K_RGB, bgc(100, 0), "tog_l0_lx4_hold");
    expect_at(b2 + 2*1440 - 1, K_HL, 6'h00, "tog_hline_ena0");
    expect_at(b2 + 2*1440,     K_HL, 6'h01, "tog_hline_ena1");
    expect_at(b2 + 2*(1600+219) + 1, K_RGB, 6'h3f,       "tog_l2_lx123");
    expect_at(b2 + 2*(1600+219) + 2, K_RGB, 6'h3f,       "tog_l2_lx123_hold");
    expect_at(b2 + 2*(1600+220) + 1, K_RGB, bgc(220, 2), "tog_l2_lx124");
    expect_at(b2 + 2*(1600+220) + 2, K_RGB, bgc(220, 2), "tog_l2_lx124_hold");

    while (cyc < b2 + 2*(1600+300)) begin
      step(); bus.ena = 1'b0;
      step(); bus.ena = 1'b1;
    end

    repeat (20) step();
    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      nchk++;
      nfail++;
      $display("FAIL %s: never checked (slot %0d)", mon_e.name, mon_e.cyc);
    end

    $display("[TB] %0d tests run, %0d failed", nchk, nfail);
    $finish;
  end

endmodule
